mem_arbiter: RTL
================

# mem_arbiter

Sequencing controller and two-port arbiter in front of the 128-bit-line main memory. It shares the single memory port between instruction-cache refills (read-only) and data-cache refills/writebacks (read or write). It models a fixed memory access latency with a countdown. It also drives the memory's read address, write address, write data and write-enable so that each access is issued exactly once.

## Interface
Parameters:
- LATENCY, 5, memory access latency in cycles (BUSY-state length); legal range 1..15
- ADDR_W, 20, physical word-address width
- LINE_W, 128, line width in bits (4 × 32-bit words)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset; one clock (`clk`), reset is synchronous and active-high
- ic_req  in  1  icache read request; held with ic_addr stable until ic_ack
- ic_addr  in  ADDR_W  icache line word address
- ic_ack  out  1  one-cycle completion pulse for icache
- ic_rdata  out  LINE_W  registered line returned to icache
- dc_req  in  1  dcache request; held with dc_we/dc_addr/dc_wdata stable until dc_ack
- dc_we  in  1  1 = writeback of dc_wdata, 0 = refill read
- dc_addr  in  ADDR_W  dcache line word address
- dc_wdata  in  LINE_W  writeback line
- dc_ack  out  1  one-cycle completion pulse for dcache
- dc_rdata  out  LINE_W  registered line returned to dcache (reads only)
- mem_rd_addr  out  ADDR_W  word address to memory read port
- mem_wr_addr  out  ADDR_W  line index to memory write port (memory scales by 4)
- mem_wdata  out  LINE_W  line to write
- mem_we  out  1  memory write enable
- mem_rdata  in  LINE_W  combinational read line from memory
- busy  out  1  high in BUSY and DONE

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if any req is high, grant one requester and latch its id, we, addr and wdata. addr[1:0] is forced to 0. Load cnt = LATENCY-1, go BUSY. With no req, stay in IDLE.
- Default arbitration is fixed priority: dcache wins ties.
- BUSY: drive mem_rd_addr = latched addr and mem_wr_addr = {2'b00, latched addr[ADDR_W-1:2]} from the latch registers.
- BUSY, cnt != 0: cnt decrements.
- BUSY, cnt == 0: for a read, capture mem_rdata into the granted requester's rdata register; for a write, mem_we = 1 this cycle only. Go to DONE.
- DONE: assert the granted requester's ack for one cycle, then go to IDLE.
- mem_we is high only in the final BUSY cycle of a write. One request produces one memory write, never more.
- A read leaves the other requester's rdata register unchanged. A dcache write leaves dc_rdata unchanged.
- Requesters drop req on the edge that ends their ack cycle. A req still high in IDLE is a new request.
- The ungranted requester's req may stay high across the whole transaction. It is served in the next IDLE.
- Reset values, applied at any time including mid-transaction: state IDLE, cnt 0, ic_ack/dc_ack 0, mem_we 0, busy 0, ic_rdata/dc_rdata 0, all mem address/data outputs 0, RR pointer = dcache last-granted.
- Reset during BUSY aborts the access: no write is issued and no ack is given.

## Timing
- Request first high in cycle 0 (state IDLE) → BUSY in cycles 1..LATENCY → ack in cycle LATENCY+1 → IDLE in cycle LATENCY+2.
- Read data is valid on *_rdata from cycle LATENCY+1 and is held until the next read for that requester.
- A write is committed at the end of cycle LATENCY.
- Minimum request-to-request spacing is LATENCY+2 cycles. There is no pipelining.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. On a tie, grant the requester not granted last. The pointer updates on each grant; after reset the icache wins the first tie.
- MEM_ARB_RR_EN undefined: fixed dcache priority. The pointer logic is absent.

## Structure
- Package mem_arb_pkg: ADDR_W/LINE_W defaults, state enum (IDLE/BUSY/DONE), requester id enum (REQ_IC/REQ_DC).
- Sub-module mem_arb_pick: combinational grant selection from ic_req, dc_req and the RR pointer, with the pointer register under MEM_ARB_RR_EN.
- The FSM, counter and latches stay in mem_arbiter.

## Test plan
- LATENCY=5, ic_req with ic_addr=0x01000 in cycle 0 → mem_rd_addr=0x01000 in cycles 1–5; ic_ack only in cycle 6; ic_rdata = mem_rdata sampled in cycle 5; mem_we never high.
- dc write, dc_addr=0x00400, dc_wdata=128'h…DEADBEEF → mem_we high only in cycle 5 with mem_wr_addr=0x00100 and mem_wdata=dc_wdata; dc_ack in cycle 6; dc_rdata unchanged.
- ic_req and dc_req both rise in cycle 0 → without RR: dc_ack cycle 6, ic_ack cycle 13. With MEM_ARB_RR_EN: ic_ack cycle 6, dc_ack cycle 13.
- Reset asserted in cycle 3 of a dc write → mem_we never high, no ack, all outputs 0. The req held high after reset is re-accepted and acked 6 cycles after the first IDLE cycle.
- ic_addr=0x01003 → mem_rd_addr=0x01000.
- ic_req held high through ack → second transaction accepted in cycle 7, ic_ack again in cycle 13.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and defaults for the main-memory arbiter:
//               width defaults, FSM state encoding and requester ids.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int LINE_W_DEF = 128;
    // Countdown width; covers LATENCY up to 15.
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Grant selection between icache and dcache requests.
//               Build option MEM_ARB_RR_EN: round-robin on ties using a
//               last-granted pointer; otherwise dcache has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    i_ic_req,
    input  logic    i_dc_req,
    input  logic    i_take,     // grant is being accepted this cycle
    output req_id_t o_grant
);

`ifdef MEM_ARB_RR_EN
    req_id_t r_last;

    // Remember who won the most recent grant; reset favours icache next.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= REQ_DC;
        end else if (i_take) begin
            r_last <= o_grant;
        end
    end

    // On a tie serve whoever was not granted last.
    always_comb begin
        o_grant = REQ_IC;
        if (i_ic_req && i_dc_req) begin
            if (r_last == REQ_DC) begin
                o_grant = REQ_IC;
            end else begin
                o_grant = REQ_DC;
            end
        end else if (i_dc_req) begin
            o_grant = REQ_DC;
        end
    end
`else
    // Fixed priority needs no state.
    logic w_unused_pick;
    assign w_unused_pick = &{1'b0, clk, reset, i_take};

    // dcache wins whenever it is requesting.
    always_comb begin
        o_grant = REQ_IC;
        if (i_dc_req) begin
            o_grant = REQ_DC;
        end
    end
`endif

endmodule : mem_arb_pick
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Sequencer sharing one main-memory port between icache
//               refills and dcache refills/writebacks, with a fixed access
//               latency. Build option MEM_ARB_RR_EN selects round-robin
//               arbitration (see mem_arb_pick).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 5,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ack,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_ack,
    output logic [LINE_W-1:0] dc_rdata,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [LINE_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    req_id_t           r_id;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_ic_rdata;
    logic [LINE_W-1:0] r_dc_rdata;

    logic              w_any_req;
    logic              w_take;
    logic              w_last_beat;
    req_id_t           w_grant;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_unused_lsbs;

    assign w_any_req  = ic_req | dc_req;
    assign w_sel_addr = (w_grant == REQ_DC) ? dc_addr : ic_addr;
    // Low word bits are dropped: every access is line aligned.
    assign w_unused_lsbs = ^w_sel_addr[1:0];

    mem_arb_pick u_pick (
        .clk      (clk),
        .reset    (reset),
        .i_ic_req (ic_req),
        .i_dc_req (dc_req),
        .i_take   (w_take),
        .o_grant  (w_grant)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the per-state strobes (ack, write enable, busy).
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_last_beat = 1'b0;
        mem_we      = 1'b0;
        ic_ack      = 1'b0;
        dc_ack      = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_take      = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_last_beat = 1'b1;
                    mem_we      = r_we;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                ic_ack      = (r_id == REQ_IC);
                dc_ack      = (r_id == REQ_DC);
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, latency countdown and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_id       <= REQ_DC;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ic_rdata <= '0;
            r_dc_rdata <= '0;
        end else begin
            if (w_take) begin
                r_id    <= w_grant;
                r_we    <= (w_grant == REQ_DC) && dc_we;
                r_addr  <= {w_sel_addr[ADDR_W-1:2], 2'b00};
                r_wdata <= (w_grant == REQ_DC) ? dc_wdata : '0;
                r_cnt   <= C_CNT_LOAD;
            end else if ((r_state == BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_last_beat && !r_we) begin
                if (r_id == REQ_IC) begin
                    r_ic_rdata <= mem_rdata;
                end else begin
                    r_dc_rdata <= mem_rdata;
                end
            end
        end
    end

    // Memory port is driven straight from the latch; the write side is a line index.
    assign mem_rd_addr = r_addr;
    assign mem_wr_addr = {2'b00, r_addr[ADDR_W-1:2]};
    assign mem_wdata   = r_wdata;
    assign ic_rdata    = r_ic_rdata;
    assign dc_rdata    = r_dc_rdata;

endmodule : mem_arbiter
`default_nettype wire
